// File: rtl/typ_cnt_arbiter.sv
// Round-robin arbiter feeding one shared accumulator of parameterized type TYP.
// Define TYP_CNT_ARB_SAT_EN for saturating adds with a sticky sat flag; otherwise adds wrap.
module typ_cnt_arbiter #(
    parameter type         TYP = byte,
    parameter int unsigned N   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  TYP           add [N],
    output logic [N-1:0] gnt,
    output TYP           cnt,
    output logic         busy,
    output logic         sat,
    output int           siz
);

    localparam int unsigned W  = $bits(TYP);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] UPD  = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] win_q;
    logic          found;
    logic [W-1:0]  opnd_q;
    logic [W-1:0]  cnt_q;
    logic [N-1:0]  gnt_q;

    // First set request at or after ptr, wrapping modulo N.
    always_comb begin
        logic [PW-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef TYP_CNT_ARB_SAT_EN
    logic [W:0] sum;
    logic       sat_q;
    assign sum = {1'b0, cnt_q} + {1'b0, opnd_q};
    assign sat = sat_q;
`else
    logic [W-1:0] sum;
    assign sum = cnt_q + opnd_q;
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            win_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            gnt_q  <= '0;
            busy   <= 1'b0;
`ifdef TYP_CNT_ARB_SAT_EN
            sat_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt_q <= '0;
                    if (found) begin
                        win_q      <= win;
                        opnd_q     <= add[win];
                        gnt_q[win] <= 1'b1;
                        busy       <= 1'b1;
                        state      <= UPD;
                    end
                end
                default: begin
                    gnt_q <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    ptr   <= (32'(win_q) + 1 == N) ? '0 : win_q + 1'b1;
`ifdef TYP_CNT_ARB_SAT_EN
                    if (sum[W]) begin
                        cnt_q <= '1;
                        sat_q <= 1'b1;
                    end else begin
                        cnt_q <= sum[W-1:0];
                    end
`else
                    cnt_q <= sum;
`endif
                end
            endcase
        end
    end

    // An update aborted by reset during UPD must not be reported as served.
    assign gnt  = rst ? '0 : gnt_q;
    assign cnt  = cnt_q;
    assign siz  = int'(W);

endmodule

// File: tb/tb_typ_cnt_arbiter.sv
// Self-checking bench for typ_cnt_arbiter: cycle model plus grant scoreboard on a byte/N=4
// instance, and small side instances for the type sweep and N=1 behaviour.
module tb_typ_cnt_arbiter;

    localparam int unsigned N = 4;
`ifdef TYP_CNT_ARB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef bit [23:0]      b24_t;
    typedef bit [3:0][3:0]  b16_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    byte          add [N];
    logic [N-1:0] gnt;
    byte          cnt;
    logic         busy, sat;
    int           siz;
    logic [7:0]   cnt_u;
    assign cnt_u = cnt;

    typ_cnt_arbiter #(.TYP(byte), .N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .add(add),
        .gnt(gnt), .cnt(cnt), .busy(busy), .sat(sat), .siz(siz)
    );

    int         add_i [2];
    logic [1:0] gnt_i;
    int         cnt_i;
    logic       busy_i, sat_i;
    int         siz_i;
    typ_cnt_arbiter #(.TYP(int), .N(2)) u_int (
        .clk(clk), .rst(rst), .req(2'b00), .add(add_i),
        .gnt(gnt_i), .cnt(cnt_i), .busy(busy_i), .sat(sat_i), .siz(siz_i)
    );

    b24_t       add_w [3];
    logic [2:0] gnt_w;
    b24_t       cnt_w;
    logic       busy_w, sat_w;
    int         siz_w;
    typ_cnt_arbiter #(.TYP(b24_t), .N(3)) u_b24 (
        .clk(clk), .rst(rst), .req(3'b000), .add(add_w),
        .gnt(gnt_w), .cnt(cnt_w), .busy(busy_w), .sat(sat_w), .siz(siz_w)
    );

    b16_t       add_h [2];
    logic [1:0] gnt_h;
    b16_t       cnt_h;
    logic       busy_h, sat_h;
    int         siz_h;
    typ_cnt_arbiter #(.TYP(b16_t), .N(2)) u_b16 (
        .clk(clk), .rst(rst), .req(2'b00), .add(add_h),
        .gnt(gnt_h), .cnt(cnt_h), .busy(busy_h), .sat(sat_h), .siz(siz_h)
    );

    logic [0:0] req_b = '0;
    bit         add_b [1];
    logic [0:0] gnt_b;
    bit         cnt_b;
    logic       busy_b, sat_b;
    int         siz_b;
    typ_cnt_arbiter #(.TYP(bit), .N(1)) u_bit (
        .clk(clk), .rst(rst), .req(req_b), .add(add_b),
        .gnt(gnt_b), .cnt(cnt_b), .busy(busy_b), .sat(sat_b), .siz(siz_b)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of the byte/N=4 instance
    bit          m_upd = 1'b0;
    int unsigned m_ptr = 0;
    int unsigned m_win = 0;
    logic [7:0]  m_opnd = '0;
    logic [7:0]  m_cnt = '0;
    bit          m_sat = 1'b0;
    int unsigned sb [$];
    int unsigned glog [$];

    task automatic model_edge();
        logic [8:0]  s;
        int unsigned j;
        if (rst) begin
            m_upd = 1'b0;
            m_ptr = 0;
            m_cnt = '0;
            m_sat = 1'b0;
            sb.delete();
        end else if (m_upd) begin
            s = {1'b0, m_cnt} + {1'b0, m_opnd};
            if (SAT && s[8]) begin
                m_cnt = 8'hFF;
                m_sat = 1'b1;
            end else begin
                m_cnt = s[7:0];
            end
            m_ptr = (m_win + 1) % N;
            m_upd = 1'b0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!m_upd && req[j[1:0]]) begin
                    m_upd  = 1'b1;
                    m_win  = j;
                    m_opnd = add[j[1:0]];
                    sb.push_back(j);
                end
            end
        end
    endtask

    task automatic observe();
        int unsigned w;
        check("busy", 64'(busy), 64'(m_upd));
        check("sat", 64'(sat), 64'(m_sat));
        check("cnt", 64'(cnt_u), 64'(m_cnt));
        check("gnt_onehot", 64'($countones(gnt) <= 1), 64'(1));
        for (int unsigned i = 0; i < N; i++)
            if (gnt[i[1:0]]) glog.push_back(i);
        if (m_upd && !rst && sb.size() > 0) begin
            w = sb.pop_front();
            check("gnt", 64'(gnt), 64'(1) << w);
        end else begin
            check("gnt_idle", 64'(gnt), 64'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        observe();
    endtask

    task automatic one_req(input logic [N-1:0] mask, input logic [7:0] val);
        req = mask;
        for (int unsigned i = 0; i < N; i++) add[i] = byte'(val);
        tick();
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        for (int unsigned i = 0; i < N; i++) add[i] = 0;
        add_i = '{7, 9};
        add_w = '{24'd1, 24'd2, 24'd3};
        add_h = '{16'h1234, 16'h0001};
        add_b = '{1'b0};

        // T1: reset, plus the type sweep on sizes
        rst = 1'b1;
        tick();
        check("siz_in_rst", 64'(siz), 64'(8));
        tick();
        check("t1_cnt", 64'(cnt_u), 64'(0));
        check("t1_gnt", 64'(gnt), 64'(0));
        check("t1_busy", 64'(busy), 64'(0));
        check("t1_sat", 64'(sat), 64'(0));
        check("siz_int", 64'(siz_i), 64'(32));
        check("siz_b24", 64'(siz_w), 64'(24));
        check("siz_b16", 64'(siz_h), 64'(16));
        check("siz_bit", 64'(siz_b), 64'(1));
        check("side_idle", 64'({cnt_i, cnt_w, cnt_h, gnt_i, gnt_w, gnt_h, busy_i, busy_w, busy_h,
                                sat_i, sat_w, sat_h, sat_b}), 64'(0));
        rst = 1'b0;

        // T5: TYP=bit, N=1, req held: grants alternate with idle cycles, count wraps 1 -> 0
        req_b = 1'b1;
        add_b[0] = 1'b1;
        tick();
        check("bit_gnt0", 64'(gnt_b), 64'(1));
        check("bit_busy0", 64'(busy_b), 64'(1));
        check("bit_cnt0", 64'(cnt_b), 64'(0));
        tick();
        check("bit_gnt1", 64'(gnt_b), 64'(0));
        check("bit_cnt1", 64'(cnt_b), 64'(1));
        tick();
        check("bit_gnt2", 64'(gnt_b), 64'(1));
        req_b = 1'b0;
        tick();
        check("bit_cnt3", 64'(cnt_b), 64'(0));
        tick();
        check("bit_gnt4", 64'(gnt_b), 64'(0));

        // T2: single requester
        req = 4'b0001;
        add[0] = 3;
        tick();
        check("t2_busy", 64'(busy), 64'(1));
        check("t2_gnt", 64'(gnt), 64'(4'b0001));
        req = '0;
        tick();
        check("t2_cnt", 64'(cnt_u), 64'(3));
        tick();
        tick();
        check("t2_quiet", 64'(gnt), 64'(0));

        // T3: fairness with all requesters held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        glog.delete();
        req = 4'b1111;
        for (int unsigned i = 0; i < N; i++) add[i] = 1;
        repeat (16) tick();
        req = '0;
        tick();
        check("t3_len", 64'(glog.size()), 64'(8));
        for (int unsigned i = 0; i < 8; i++)
            if (i < glog.size()) check("t3_order", 64'(glog[i]), 64'(i % 4));
        check("t3_cnt", 64'(cnt_u), 64'(8));

        // T4: overflow, then a zero add leaves the count and sticky flag alone
        rst = 1'b1;
        tick();
        rst = 1'b0;
        one_req(4'b0001, 8'd250);
        check("t4_pre", 64'(cnt_u), 64'(250));
        one_req(4'b0010, 8'd10);
        check("t4_cnt", 64'(cnt_u), SAT ? 64'(255) : 64'(4));
        check("t4_sat", 64'(sat), 64'(SAT));
        one_req(4'b0100, 8'd0);
        check("t4_zero", 64'(cnt_u), SAT ? 64'(255) : 64'(4));
        check("t4_sticky", 64'(sat), 64'(SAT));

        // T6: reset during UPD drops the pending add
        rst = 1'b1;
        tick();
        rst = 1'b0;
        one_req(4'b0001, 8'd7);
        req = 4'b0100;
        for (int unsigned i = 0; i < N; i++) add[i] = 5;
        @(posedge clk);
        model_edge();
        #1 rst = 1'b1;
        req = '0;
        @(negedge clk);
        observe();
        check("t6_nognt", 64'(gnt), 64'(0));
        tick();
        rst = 1'b0;
        check("t6_cnt", 64'(cnt_u), 64'(0));
        req = 4'b0010;
        tick();
        check("t6_gnt1", 64'(gnt), 64'(4'b0010));
        req = '0;
        tick();
        check("t6_cnt5", 64'(cnt_u), 64'(5));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
